// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin front end driving a two-slave APB bus, one transfer at a time.
// Define APB_ARB_TIMEOUT_EN to bound PREADY wait states at TIMEOUT_CYCLES ACCESS cycles.
module apb_req_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        pclk,
    input  logic        Reset,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_strb,
    output logic [1:0]  req_done,
    output logic [31:0] req_rdata,
    output logic        req_err,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic [3:0]  PSTRB,
    output logic        PENABLE,
    output logic [1:0]  PSEL,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t      state_reg;
    logic        grant_reg;
    logic        last_grant_reg;
    logic [1:0]  eligible;
    logic        pick;
    logic        timeout_hit;

    logic [31:0] addr_arr  [2];
    logic [31:0] wdata_arr [2];
    logic [3:0]  strb_arr  [2];

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr[32*gi +: 32];
        assign wdata_arr[gi] = req_wdata[32*gi +: 32];
        assign strb_arr[gi]  = req_strb[4*gi +: 4];
    end

    // A requester whose done pulse is on the wire still shows valid this cycle; skip it.
    always_comb begin
        eligible = req_valid & ~req_done;
        if (eligible == 2'b11) begin
            pick = ~last_grant_reg;
        end else begin
            pick = eligible[1];
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] wait_cnt_reg;

    assign timeout_hit = (wait_cnt_reg + 8'd1) == TIMEOUT_LIMIT;

    always_ff @(posedge pclk or negedge Reset) begin
        if (!Reset) begin
            wait_cnt_reg <= 8'd0;
        end else if (state_reg == SETUP) begin
            wait_cnt_reg <= 8'd0;
        end else if (state_reg == ACCESS && !PREADY) begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
        end
    end
`else
    // Without the wait-state limit the parameter has no effect.
    logic [7:0] timeout_unused;

    assign timeout_unused = 8'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge pclk or negedge Reset) begin
        if (!Reset) begin
            state_reg      <= IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            PADDR          <= 32'd0;
            PWDATA         <= 32'd0;
            PWRITE         <= 1'b0;
            PSTRB          <= 4'd0;
            PENABLE        <= 1'b0;
            PSEL           <= 2'b00;
            req_done       <= 2'b00;
            req_rdata      <= 32'd0;
            req_err        <= 1'b0;
        end else begin
            req_done <= 2'b00;
            case (state_reg)
                IDLE: begin
                    if (eligible != 2'b00) begin
                        grant_reg      <= pick;
                        last_grant_reg <= pick;
                        PADDR          <= addr_arr[pick];
                        PWDATA         <= wdata_arr[pick];
                        PWRITE         <= req_write[pick];
                        PSTRB          <= req_write[pick] ? strb_arr[pick] : 4'b0000;
                        PSEL           <= addr_arr[pick][31] ? 2'b10 : 2'b01;
                        PENABLE        <= 1'b0;
                        state_reg      <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE   <= 1'b1;
                    state_reg <= ACCESS;
                end
                ACCESS: begin
                    // PREADY wins over a timeout landing in the same cycle.
                    if (PREADY || timeout_hit) begin
                        req_done  <= grant_reg ? 2'b10 : 2'b01;
                        req_rdata <= (PREADY && !PWRITE) ? PRDATA : 32'd0;
                        req_err   <= PREADY ? PSLVERR : 1'b1;
                        PSEL      <= 2'b00;
                        PENABLE   <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    PSEL      <= 2'b00;
                    PENABLE   <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: directed vector table, hand sequences and a
// randomized run against a transaction-level model (honours APB_ARB_TIMEOUT_EN).
module tb_apb_req_arbiter;

    localparam int TO = 4;

    logic        pclk = 1'b0;
    logic        Reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_strb;
    logic [1:0]  req_done;
    logic [31:0] req_rdata;
    logic        req_err;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic [3:0]  PSTRB;
    logic        PENABLE;
    logic [1:0]  PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_tests = 0;
    int n_fail  = 0;

    apb_req_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .pclk      (pclk),
        .Reset     (Reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .req_done  (req_done),
        .req_rdata (req_rdata),
        .req_err   (req_err),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PWRITE    (PWRITE),
        .PSTRB     (PSTRB),
        .PENABLE   (PENABLE),
        .PSEL      (PSEL),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int          req;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
        logic [1:0]  exp_psel;
        logic [3:0]  exp_pstrb;
        int          exp_access;
        logic [1:0]  exp_done;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_cmd(input int i, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        req_write[i]          = w;
        req_addr[i*32 +: 32]  = a;
        req_wdata[i*32 +: 32] = d;
        req_strb[i*4 +: 4]    = s;
    endtask

    // One isolated transfer; called and returns on a falling edge with the arbiter idle.
    task automatic run_xfer(input int idx, input vec_t v);
        int k;
        set_cmd(v.req, v.write, v.addr, v.wdata, v.strb);
        req_valid = 2'b01 << v.req;
        PREADY    = 1'b0;
        PRDATA    = v.prdata;
        PSLVERR   = v.slverr;
        @(negedge pclk);
        check("setup_psel", PSEL, v.exp_psel);
        check("setup_penable", PENABLE, 0);
        check("setup_paddr", PADDR, v.addr);
        check("setup_pwrite", PWRITE, v.write);
        check("setup_pstrb", PSTRB, v.exp_pstrb);
        check("setup_done", req_done, 0);
        for (k = 0; k < 400; k++) begin
            @(negedge pclk);
            if (req_done != 2'b00) break;
            check("access_psel", PSEL, v.exp_psel);
            check("access_penable", PENABLE, 1);
            check("access_paddr", PADDR, v.addr);
            check("access_pwrite", PWRITE, v.write);
            check("access_pstrb", PSTRB, v.exp_pstrb);
            check("access_pwdata", PWDATA, v.wdata);
            PREADY = (k >= v.waits);
        end
        check("access_cycles", k, v.exp_access);
        check("done_bits", req_done, v.exp_done);
        check("done_rdata", req_rdata, v.exp_rdata);
        check("done_err", req_err, v.exp_err);
        check("done_psel", PSEL, 0);
        check("done_penable", PENABLE, 0);
        $display("[TB] vec %0d req%0d wr=%0b addr=%h access=%0d done=%b rdata=%h err=%0b",
                 idx, v.req, v.write, v.addr, k, req_done, req_rdata, req_err);
        req_valid = 2'b00;
        PREADY    = 1'b0;
        @(negedge pclk);
        check("done_one_cycle", req_done, 0);
        check("idle_psel", PSEL, 0);
    endtask

    // Transaction-level reference: rules for grant, phase sequence and completion.
    task automatic random_phase(input int cycles);
        int          phase = 0;   // 0 idle, 1 setup, 2 access
        int          waitc = 0;
        int          g = 0;
        int          dones = 0;
        logic        last = 1'b1;
        logic [1:0]  prev_valid = 2'b00;
        logic [1:0]  prev_done = 2'b00;
        logic        prev_ready = 1'b0;
        logic        prev_slverr = 1'b0;
        logic [31:0] prev_prdata = 32'd0;
        logic [1:0]  elig;
        logic [1:0]  exp_done;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        gw = 1'b0;
        logic [31:0] ga = 32'd0;
        logic [31:0] gd = 32'd0;
        logic [3:0]  gs = 4'd0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge pclk);
            exp_done  = 2'b00;
            exp_rdata = 32'd0;
            exp_err   = 1'b0;
            case (phase)
                0: begin
                    elig = prev_valid & ~prev_done;
                    if (elig != 2'b00) begin
                        if (elig == 2'b11) g = last ? 0 : 1;
                        else               g = elig[1] ? 1 : 0;
                        last  = (g == 1);
                        gw    = req_write[g];
                        ga    = req_addr[g*32 +: 32];
                        gd    = req_wdata[g*32 +: 32];
                        gs    = req_strb[g*4 +: 4];
                        phase = 1;
                    end
                end
                1: begin
                    phase = 2;
                    waitc = 0;
                end
                default: begin
                    if (prev_ready) begin
                        exp_done[g] = 1'b1;
                        exp_rdata   = gw ? 32'd0 : prev_prdata;
                        exp_err     = prev_slverr;
                        phase       = 0;
                    end else begin
                        waitc++;
`ifdef APB_ARB_TIMEOUT_EN
                        if (waitc == TO) begin
                            exp_done[g] = 1'b1;
                            exp_err     = 1'b1;
                            phase       = 0;
                        end
`endif
                    end
                end
            endcase

            check("rnd_done", req_done, exp_done);
            check("rnd_psel", PSEL, (phase == 0) ? 2'b00 : (ga[31] ? 2'b10 : 2'b01));
            check("rnd_penable", PENABLE, phase == 2);
            if (phase != 0) begin
                check("rnd_paddr", PADDR, ga);
                check("rnd_pwrite", PWRITE, gw);
                check("rnd_pstrb", PSTRB, gw ? gs : 4'b0000);
                check("rnd_pwdata", PWDATA, gd);
            end
            if (exp_done != 2'b00) begin
                check("rnd_rdata", req_rdata, exp_rdata);
                check("rnd_err", req_err, exp_err);
                dones++;
                $display("[TB] rnd xfer %0d req%0d wr=%0b addr=%h rdata=%h err=%0b",
                         dones, g, gw, ga, req_rdata, req_err);
            end
            prev_done = exp_done;

            for (int i = 0; i < 2; i++) begin
                if (exp_done[i]) begin
                    set_cmd(i, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
                    req_valid[i] = 1'($urandom_range(0, 1));
                end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    set_cmd(i, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
                    req_valid[i] = 1'b1;
                end
            end
            PREADY      = 1'($urandom_range(0, 1));
            PRDATA      = $urandom;
            PSLVERR     = ($urandom_range(0, 3) == 0);
            prev_valid  = req_valid;
            prev_ready  = PREADY;
            prev_prdata = PRDATA;
            prev_slverr = PSLVERR;
        end
        check("rnd_enough_transfers", dones >= 50, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int cnt;
        logic [1:0] eg;

        vecs[0] = '{0, 1'b1, 32'h00111111, 32'hDEAD2023, 4'hF, 0, 32'hAAAA5555, 1'b0,
                    2'b01, 4'hF, 1, 2'b01, 32'h0, 1'b0};
`ifdef APB_ARB_TIMEOUT_EN
        vecs[1] = '{1, 1'b0, 32'h80000004, 32'h0, 4'hF, 5, 32'h12345678, 1'b0,
                    2'b10, 4'h0, 4, 2'b10, 32'h0, 1'b1};
`else
        vecs[1] = '{1, 1'b0, 32'h80000004, 32'h0, 4'hF, 5, 32'h12345678, 1'b0,
                    2'b10, 4'h0, 6, 2'b10, 32'h12345678, 1'b0};
`endif
        vecs[2] = '{0, 1'b1, 32'h80000010, 32'h01020304, 4'b0101, 0, 32'h0, 1'b1,
                    2'b10, 4'b0101, 1, 2'b01, 32'h0, 1'b1};
        vecs[3] = '{0, 1'b0, 32'h00000020, 32'h77777777, 4'hF, 2, 32'hCAFEF00D, 1'b0,
                    2'b01, 4'h0, 3, 2'b01, 32'hCAFEF00D, 1'b0};
        vecs[4] = '{1, 1'b0, 32'h7FFFFFFC, 32'h0, 4'h3, 3, 32'h0BADBEEF, 1'b1,
                    2'b01, 4'h0, 4, 2'b10, 32'h0BADBEEF, 1'b1};
`ifdef APB_ARB_TIMEOUT_EN
        vecs[5] = '{1, 1'b1, 32'hFFFF0ABC, 32'h5A5A5A5A, 4'b1000, 4, 32'h13579BDF, 1'b0,
                    2'b10, 4'b1000, 4, 2'b10, 32'h0, 1'b1};
`else
        vecs[5] = '{1, 1'b1, 32'hFFFF0ABC, 32'h5A5A5A5A, 4'b1000, 4, 32'h13579BDF, 1'b0,
                    2'b10, 4'b1000, 5, 2'b10, 32'h0, 1'b0};
`endif

        Reset     = 1'b0;
        req_valid = 2'b00;
        req_write = 2'b00;
        req_addr  = 64'd0;
        req_wdata = 64'd0;
        req_strb  = 8'd0;
        PRDATA    = 32'd0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        #1;
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_pwrite", PWRITE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_pstrb", PSTRB, 0);
        check("rst_done", req_done, 0);
        check("rst_rdata", req_rdata, 0);
        check("rst_err", req_err, 0);
        repeat (2) @(negedge pclk);
        Reset = 1'b1;

        // Tie: both requesters held valid for four transfers.
        set_cmd(0, 1'b1, 32'h00000100, 32'h11110000, 4'b0011);
        set_cmd(1, 1'b0, 32'h80000200, 32'h0, 4'hF);
        req_valid = 2'b11;
        PREADY    = 1'b1;
        PRDATA    = 32'h55AA0001;
        for (int t = 0; t < 4; t++) begin
            eg = (t % 2 == 0) ? 2'b01 : 2'b10;
            for (w = 0; w < 20; w++) begin
                @(negedge pclk);
                if (PSEL != 2'b00) break;
            end
            check("rr_setup_gap", w, 0);
            check("rr_psel", PSEL, eg);
            check("rr_paddr", PADDR, (t % 2 == 0) ? 32'h00000100 : 32'h80000200);
            check("rr_setup_penable", PENABLE, 0);
            @(negedge pclk);
            check("rr_access_penable", PENABLE, 1);
            @(negedge pclk);
            check("rr_done", req_done, eg);
            check("rr_done_psel", PSEL, 0);
            check("rr_rdata", req_rdata, (t % 2 == 0) ? 32'h0 : 32'h55AA0001);
            $display("[TB] rr xfer %0d done=%b rdata=%h", t, req_done, req_rdata);
            if (t == 3) req_valid = 2'b00;
        end
        PREADY = 1'b0;
        @(negedge pclk);
        check("rr_final_idle_psel", PSEL, 0);
        check("rr_final_done", req_done, 0);

        for (int i = 0; i < 6; i++) run_xfer(i, vecs[i]);

        // Reset while waiting in ACCESS.
        set_cmd(0, 1'b0, 32'h00000004, 32'h0, 4'hF);
        req_valid = 2'b01;
        PREADY    = 1'b0;
        @(negedge pclk);
        check("rstmid_setup_psel", PSEL, 2'b01);
        @(negedge pclk);
        check("rstmid_access_penable", PENABLE, 1);
        #2 Reset = 1'b0;
        #1;
        check("rstmid_psel", PSEL, 0);
        check("rstmid_penable", PENABLE, 0);
        check("rstmid_paddr", PADDR, 0);
        check("rstmid_done", req_done, 0);
        @(negedge pclk);
        check("rstmid_hold_done", req_done, 0);
        Reset  = 1'b1;
        PREADY = 1'b1;
        @(negedge pclk);
        check("rstmid_restart_psel", PSEL, 2'b01);
        check("rstmid_restart_penable", PENABLE, 0);
        check("rstmid_restart_done", req_done, 0);
        @(negedge pclk);
        check("rstmid_restart_access", PENABLE, 1);
        @(negedge pclk);
        check("rstmid_restart_complete", req_done, 2'b01);
        $display("[TB] reset-recovery xfer done=%b err=%0b", req_done, req_err);
        req_valid = 2'b00;
        PREADY    = 1'b0;
        @(negedge pclk);

        // PREADY stuck low.
        set_cmd(1, 1'b0, 32'h80000040, 32'h0, 4'hF);
        req_valid = 2'b10;
        PRDATA    = 32'hFEEDFACE;
        PSLVERR   = 1'b0;
        @(negedge pclk);
        check("stuck_setup_psel", PSEL, 2'b10);
`ifdef APB_ARB_TIMEOUT_EN
        for (cnt = 0; cnt < 50; cnt++) begin
            @(negedge pclk);
            if (req_done != 2'b00) break;
        end
        check("stuck_timeout_cycles", cnt, TO);
        check("stuck_timeout_done", req_done, 2'b10);
        check("stuck_timeout_err", req_err, 1);
        check("stuck_timeout_rdata", req_rdata, 0);
        check("stuck_timeout_psel", PSEL, 0);
        $display("[TB] stuck xfer timed out after %0d access cycles", cnt);
`else
        cnt = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge pclk);
            if (req_done != 2'b00 || PENABLE != 1'b1) cnt++;
        end
        check("stuck_no_done_300", cnt, 0);
        PREADY = 1'b1;
        @(negedge pclk);
        check("stuck_release_done", req_done, 2'b10);
        check("stuck_release_rdata", req_rdata, 32'hFEEDFACE);
        check("stuck_release_err", req_err, 0);
        $display("[TB] stuck xfer released after 300 wait cycles done=%b", req_done);
`endif
        req_valid = 2'b00;
        PREADY    = 1'b0;
        @(negedge pclk);

        Reset = 1'b0;
        @(negedge pclk);
        Reset = 1'b1;
        random_phase(3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
